comp_seq_ctrl: RTL
==================

// Module: comp_seq_ctrl
// PURPOSE
//  Sequencing stage directly upstream of comp_top. Accepts two 16-bit operands as a
//  two-beat valid/ready stream and holds them stable on comp_top's in0/in1/is_signed.
//  After CMP_LATENCY cycles it captures GT/LT/ET, evaluates a condition code and
//  presents a registered result with valid/ready handshake to the consumer.
// PARAMETERS
//  WIDTH        16  operand width; must match comp_top (16)
//  CMP_LATENCY  1   cycles between operand-stable and flag sampling; legal 1..15
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      operand beat valid
//  in_ready       out  1      stage accepts operand beat
//  in_data        in   WIDTH  operand: beat 1 = A, beat 2 = B
//  in_signed      in   1      signed compare; sampled on beat A only
//  in_cond        in   3      condition code; sampled on beat A only
//  abort          in   1      synchronous flush, back to S_A
//  cmp_in0        out  WIDTH  to comp_top in0 (registered A)
//  cmp_in1        out  WIDTH  to comp_top in1 (registered B)
//  cmp_is_signed  out  1      to comp_top is_signed (registered)
//  cmp_gt/lt/et   in   1 ea   from comp_top GT/LT/ET
//  out_valid      out  1      result valid
//  out_ready      in   1      consumer accepts result
//  out_gt/lt/et   out  1 ea   captured flags
//  out_true       out  1      condition evaluated against captured flags
//  out_err        out  1      captured flags not exactly one-hot
// BEHAVIOUR
//  Reset (rst_n low, async): state S_A; op_a, op_b, sign, cond, wait counter, all
//   out_* flags and out_valid = 0; cmp_in0/cmp_in1/cmp_is_signed = 0. Beats ignored.
//  FSM: S_A -> S_B -> S_WAIT -> S_OUT -> S_A.
//  in_ready = 1 in S_A and S_B only (decoded from state); 0 in S_WAIT/S_OUT.
//  S_A: on in_valid&in_ready capture op_a<=in_data, sign<=in_signed, cond<=in_cond -> S_B.
//  S_B: on handshake capture op_b<=in_data, load counter=CMP_LATENCY-1 -> S_WAIT.
//   in_signed/in_cond on beat B are don't-care.
//  S_WAIT: cmp_* outputs stable; counter decrements each cycle; on edge where counter==0
//   register cmp_gt/lt/et into out_gt/lt/et, out_true, out_err -> S_OUT.
//  Latency: out_valid rises at the CMP_LATENCY-th rising edge after the edge accepting B.
//  S_OUT: out_valid=1; all out_* held stable until out_valid&out_ready; then -> S_A,
//   out_valid=0 next cycle (no same-cycle re-accept of A; min 3+CMP_LATENCY cycles/op).
//  out_* flags retain last result after out_valid drops, until next capture.
//  Conditions: 000 EQ=et, 001 NE=~et, 010 LT=lt, 011 LE=lt|et, 100 GT=gt,
//   101 GE=gt|et, 110 ALWAYS=1, 111 NEVER=0.
//  out_err = ~(exactly one of gt,lt,et); out_true still computed from raw flags.
//  abort: from any state, next state S_A, out_valid=0; abort beats any simultaneous
//   in/out handshake (that beat/result is dropped). op regs keep values.
//  Reset mid-operation: immediate return to reset values; no partial result emitted.
//  cmp_in0/cmp_in1 change only on A/B capture edges; no combinational path in_data->cmp_*.
// TESTING
//  1 signed: A=0xFFFF, B=0x0001, in_signed=1, cond=010 -> out_lt=1, out_true=1, out_err=0.
//  2 unsigned: same operands, in_signed=0, cond=101 -> out_gt=1, out_true=1.
//  3 equal: A=B=0x1234, cond=001 -> out_et=1, out_true=0; cond=011 -> out_true=1.
//  4 backpressure: out_ready=0 for 5 cycles -> out_valid and out_* stable, in_ready=0;
//    out_ready=1 -> out_valid=0 and in_ready=1 next cycle; latency check with CMP_LATENCY=1 and 3.
//  5 abort in S_B and in S_OUT -> next cycle state S_A, out_valid=0, in_ready=1; rst_n
//    pulse during S_WAIT -> all outputs 0 asynchronously, no out_valid afterwards.
//  6 comparator stub drives gt=lt=1 -> out_err=1; all-zero flags -> out_err=1, cond 110 -> out_true=1.

Source files
------------

// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: two-beat operand sequencer for comp_top; waits CMP_LATENCY cycles,
// captures the comparator flags, evaluates a condition code and holds the result.
module comp_seq_ctrl #(
    parameter int WIDTH       = 16,
    parameter int CMP_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic [2:0]       in_cond,
    input  logic             abort,
    output logic [WIDTH-1:0] cmp_in0,
    output logic [WIDTH-1:0] cmp_in1,
    output logic             cmp_is_signed,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_et,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_et,
    output logic             out_true,
    output logic             out_err
);
    typedef enum logic [1:0] {S_A, S_B, S_WAIT, S_OUT} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b;
    logic             sign;
    logic [2:0]       cond;
    logic [3:0]       cnt;
    logic             sel, cond_true, flag_err;

    assign cmp_in0       = op_a;
    assign cmp_in1       = op_b;
    assign cmp_is_signed = sign;
    assign in_ready      = (state == S_A) || (state == S_B);

    // cond[2] picks GT over LT for the ordered codes; cond[0] ORs in equality
    assign sel       = cond[2] ? cmp_gt : cmp_lt;
    assign cond_true = cond == 3'b110 ? 1'b1 :
                       cond == 3'b111 ? 1'b0 :
                       cond == 3'b000 ? cmp_et :
                       cond == 3'b001 ? ~cmp_et :
                       cond[0]        ? (sel | cmp_et) : sel;
    // exactly one flag set <=> odd parity and not all three
    assign flag_err  = ~((cmp_gt ^ cmp_lt ^ cmp_et) & ~(cmp_gt & cmp_lt & cmp_et));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            op_a      <= '0;
            op_b      <= '0;
            sign      <= 1'b0;
            cond      <= 3'b000;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            out_gt    <= 1'b0;
            out_lt    <= 1'b0;
            out_et    <= 1'b0;
            out_true  <= 1'b0;
            out_err   <= 1'b0;
        end else if (abort) begin
            state     <= S_A;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_A: if (in_valid) begin
                    op_a  <= in_data;
                    sign  <= in_signed;
                    cond  <= in_cond;
                    state <= S_B;
                end
                S_B: if (in_valid) begin
                    op_b  <= in_data;
                    cnt   <= 4'(CMP_LATENCY - 1);
                    state <= S_WAIT;
                end
                S_WAIT: if (cnt == 4'd0) begin
                    out_gt    <= cmp_gt;
                    out_lt    <= cmp_lt;
                    out_et    <= cmp_et;
                    out_true  <= cond_true;
                    out_err   <= flag_err;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_A;
                end
                default: state <= S_A;
            endcase
        end
    end
endmodule
